// File: rtl/dbg_run_ctrl.sv
// Debug run-control sequencer: gates instruction fetch for halt, resume and
// single-step, and tracks the last retired PC and retired-instruction count.
module dbg_run_ctrl #(
    parameter int XLEN   = 32,
    parameter int NUM_BP = 2,
    parameter int CNT_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      commit_valid,
    input  logic [XLEN-1:0]           commit_pc,
    input  logic                      commit_brk,
    input  logic                      commit_ivd,
    input  logic                      pipe_empty,
    input  logic                      ifu_fire,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_op,
    input  logic [$clog2(NUM_BP)-1:0] cmd_bp_idx,
    input  logic [XLEN-1:0]           cmd_bp_addr,
    input  logic                      cmd_bp_en,
    output logic                      fetch_en,
    output logic                      halted,
    output logic [2:0]                halt_cause,
    output logic [XLEN-1:0]           halt_pc,
    output logic [CNT_W-1:0]          retire_cnt
);

    typedef enum logic [2:0] {
        S_RUN,
        S_DRAIN,
        S_HALTED,
        S_STEP_ISSUE,
        S_STEP_WAIT
    } state_t;

    localparam logic [1:0] OP_HALT   = 2'd0;
    localparam logic [1:0] OP_RESUME = 2'd1;
    localparam logic [1:0] OP_STEP   = 2'd2;
    localparam logic [1:0] OP_SETBP  = 2'd3;

    localparam logic [2:0] CAUSE_NONE  = 3'd0;
    localparam logic [2:0] CAUSE_HOST  = 3'd1;
    localparam logic [2:0] CAUSE_STEP  = 3'd2;
    localparam logic [2:0] CAUSE_EBRK  = 3'd3;
    localparam logic [2:0] CAUSE_IVD   = 3'd4;
    localparam logic [2:0] CAUSE_BP    = 3'd5;

    state_t            state;
    logic [XLEN-1:0]   bp_addr [NUM_BP];
    logic [NUM_BP-1:0] bp_en;
    logic              bp_hit;
    logic [2:0]        stop_cause;
    logic              cmd_acc;

    assign fetch_en  = (state == S_RUN) || (state == S_STEP_ISSUE);
    assign halted    = (state == S_HALTED);
    assign cmd_ready = (state == S_RUN) || (state == S_HALTED);
    assign cmd_acc   = cmd_valid && cmd_ready;

    always_comb begin
        bp_hit = 1'b0;
        for (int i = 0; i < NUM_BP; i++) begin
            if (bp_en[i] && (bp_addr[i] == commit_pc)) begin
                bp_hit = 1'b1;
            end
        end
    end

    // Non-zero only when the retiring instruction must stop the core.
    always_comb begin
        stop_cause = CAUSE_NONE;
        if (commit_valid) begin
            if (commit_ivd) begin
                stop_cause = CAUSE_IVD;
            end else if (commit_brk) begin
                stop_cause = CAUSE_EBRK;
            end else if (bp_hit) begin
                stop_cause = CAUSE_BP;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_RUN;
            halt_cause <= CAUSE_NONE;
            halt_pc    <= '0;
            retire_cnt <= '0;
            bp_en      <= '0;
            for (int i = 0; i < NUM_BP; i++) begin
                bp_addr[i] <= '0;
            end
        end else begin
            if (commit_valid) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
                halt_pc    <= commit_pc;
            end
            if (cmd_acc && (cmd_op == OP_SETBP)) begin
                bp_addr[cmd_bp_idx] <= cmd_bp_addr;
                bp_en[cmd_bp_idx]   <= cmd_bp_en;
            end
            case (state)
                S_RUN: begin
                    if (stop_cause != CAUSE_NONE) begin
                        state      <= S_DRAIN;
                        halt_cause <= stop_cause;
                    end else if (cmd_acc && (cmd_op == OP_HALT)) begin
                        state      <= S_DRAIN;
                        halt_cause <= CAUSE_HOST;
                    end
                end
                S_DRAIN: begin
                    if (pipe_empty) begin
                        state <= S_HALTED;
                    end
                end
                S_HALTED: begin
                    if (cmd_acc && (cmd_op == OP_RESUME)) begin
                        state      <= S_RUN;
                        halt_cause <= CAUSE_NONE;
                    end else if (cmd_acc && (cmd_op == OP_STEP)) begin
                        state <= S_STEP_ISSUE;
                    end
                end
                // A commit arriving before ifu_fire still completes the step.
                S_STEP_ISSUE, S_STEP_WAIT: begin
                    if (commit_valid) begin
                        state      <= S_DRAIN;
                        halt_cause <= (stop_cause != CAUSE_NONE) ? stop_cause : CAUSE_STEP;
                    end else if ((state == S_STEP_ISSUE) && ifu_fire) begin
                        state <= S_STEP_WAIT;
                    end
                end
                default: state <= S_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_run_ctrl.sv
// Directed testbench for dbg_run_ctrl; a second instance with a 4-bit counter
// shares the stimulus to exercise retire-count wrap.
module tb_dbg_run_ctrl;

    logic        clk;
    logic        reset;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        commit_brk;
    logic        commit_ivd;
    logic        pipe_empty;
    logic        ifu_fire;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [0:0]  cmd_bp_idx;
    logic [31:0] cmd_bp_addr;
    logic        cmd_bp_en;

    logic        cmd_ready, fetch_en, halted;
    logic [2:0]  halt_cause;
    logic [31:0] halt_pc;
    logic [31:0] retire_cnt;

    logic        s_cmd_ready, s_fetch_en, s_halted;
    logic [2:0]  s_halt_cause;
    logic [31:0] s_halt_pc;
    logic [3:0]  s_retire_cnt;

    int tests;
    int errors;

    dbg_run_ctrl #(.XLEN(32), .NUM_BP(2), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .commit_valid(commit_valid), .commit_pc(commit_pc),
        .commit_brk(commit_brk), .commit_ivd(commit_ivd), .pipe_empty(pipe_empty),
        .ifu_fire(ifu_fire), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_bp_idx(cmd_bp_idx), .cmd_bp_addr(cmd_bp_addr), .cmd_bp_en(cmd_bp_en),
        .fetch_en(fetch_en), .halted(halted), .halt_cause(halt_cause), .halt_pc(halt_pc),
        .retire_cnt(retire_cnt)
    );

    dbg_run_ctrl #(.XLEN(32), .NUM_BP(2), .CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .commit_valid(commit_valid), .commit_pc(commit_pc),
        .commit_brk(commit_brk), .commit_ivd(commit_ivd), .pipe_empty(pipe_empty),
        .ifu_fire(ifu_fire), .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready), .cmd_op(cmd_op),
        .cmd_bp_idx(cmd_bp_idx), .cmd_bp_addr(cmd_bp_addr), .cmd_bp_en(cmd_bp_en),
        .fetch_en(s_fetch_en), .halted(s_halted), .halt_cause(s_halt_cause), .halt_pc(s_halt_pc),
        .retire_cnt(s_retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        commit_valid = 1'b0; commit_pc = '0; commit_brk = 1'b0; commit_ivd = 1'b0;
        ifu_fire = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0;
        cmd_bp_idx = '0; cmd_bp_addr = '0; cmd_bp_en = 1'b0;
    endtask

    task automatic do_commit(input logic [31:0] pc, input logic brk, input logic ivd);
        commit_valid = 1'b1; commit_pc = pc; commit_brk = brk; commit_ivd = ivd;
        step_clk();
        commit_valid = 1'b0; commit_brk = 1'b0; commit_ivd = 1'b0;
    endtask

    task automatic do_cmd(input logic [1:0] op);
        cmd_valid = 1'b1; cmd_op = op;
        step_clk();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        pipe_empty = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (fetch_en !== 1'b1) begin errors++; $display("[TB] FAIL reset_fetch_en: got %b expected 1", fetch_en); end
        tests++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted: got %b expected 0", halted); end
        tests++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
        tests++; if (halt_cause !== 3'd0) begin errors++; $display("[TB] FAIL reset_cause: got %0d expected 0", halt_cause); end
        tests++; if (halt_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected 0", halt_pc); end
        tests++; if (retire_cnt !== 32'd0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d expected 0", retire_cnt); end
        reset = 1'b0;
        step_clk();
    endtask

    task automatic test_run();
        do_commit(32'h8000_0000, 1'b0, 1'b0);
        do_commit(32'h8000_0004, 1'b0, 1'b0);
        do_commit(32'h8000_0008, 1'b0, 1'b0);
        tests++; if (retire_cnt !== 32'd3) begin errors++; $display("[TB] FAIL run_cnt: got %0d expected 3", retire_cnt); end
        tests++; if (halt_pc !== 32'h8000_0008) begin errors++; $display("[TB] FAIL run_pc: got %h expected 80000008", halt_pc); end
        tests++; if (fetch_en !== 1'b1 || halted !== 1'b0) begin errors++; $display("[TB] FAIL run_flags: got fetch_en=%b halted=%b expected 1/0", fetch_en, halted); end
        tests++; if (halt_cause !== 3'd0) begin errors++; $display("[TB] FAIL run_cause: got %0d expected 0", halt_cause); end
    endtask

    task automatic test_ebreak();
        pipe_empty = 1'b0;
        do_commit(32'h8000_0010, 1'b1, 1'b0);
        tests++; if (fetch_en !== 1'b0) begin errors++; $display("[TB] FAIL ebrk_fetch_off: got %b expected 0", fetch_en); end
        tests++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL ebrk_drain_ready: got %b expected 0", cmd_ready); end
        step_clk();
        tests++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL ebrk_early_halt: got %b expected 0", halted); end
        pipe_empty = 1'b1;
        step_clk();
        tests++; if (halted !== 1'b1) begin errors++; $display("[TB] FAIL ebrk_halted: got %b expected 1", halted); end
        tests++; if (halt_cause !== 3'd3) begin errors++; $display("[TB] FAIL ebrk_cause: got %0d expected 3", halt_cause); end
        tests++; if (halt_pc !== 32'h8000_0010) begin errors++; $display("[TB] FAIL ebrk_pc: got %h expected 80000010", halt_pc); end
        tests++; if (retire_cnt !== 32'd4) begin errors++; $display("[TB] FAIL ebrk_cnt: got %0d expected 4", retire_cnt); end
    endtask

    task automatic test_step();
        pipe_empty = 1'b0;
        do_cmd(2'd2);
        tests++; if (fetch_en !== 1'b1 || halted !== 1'b0) begin errors++; $display("[TB] FAIL step_issue: got fetch_en=%b halted=%b expected 1/0", fetch_en, halted); end
        tests++; if (halt_cause !== 3'd3) begin errors++; $display("[TB] FAIL step_cause_held: got %0d expected 3", halt_cause); end
        step_clk();
        tests++; if (fetch_en !== 1'b1) begin errors++; $display("[TB] FAIL step_fetch_wait: got %b expected 1", fetch_en); end
        ifu_fire = 1'b1;
        step_clk();
        ifu_fire = 1'b0;
        tests++; if (fetch_en !== 1'b0) begin errors++; $display("[TB] FAIL step_fetch_off: got %b expected 0", fetch_en); end
        step_clk();
        tests++; if (fetch_en !== 1'b0 || halted !== 1'b0) begin errors++; $display("[TB] FAIL step_wait: got fetch_en=%b halted=%b expected 0/0", fetch_en, halted); end
        do_commit(32'h8000_0014, 1'b0, 1'b0);
        pipe_empty = 1'b1;
        step_clk();
        tests++; if (halted !== 1'b1 || halt_cause !== 3'd2) begin errors++; $display("[TB] FAIL step_done: got halted=%b cause=%0d expected 1/2", halted, halt_cause); end
        tests++; if (retire_cnt !== 32'd5) begin errors++; $display("[TB] FAIL step_cnt: got %0d expected 5", retire_cnt); end
    endtask

    task automatic test_host_halt_resume();
        do_cmd(2'd1);
        tests++; if (fetch_en !== 1'b1 || halted !== 1'b0 || halt_cause !== 3'd0) begin errors++; $display("[TB] FAIL resume1: got fetch_en=%b halted=%b cause=%0d expected 1/0/0", fetch_en, halted, halt_cause); end
        do_cmd(2'd2);
        tests++; if (fetch_en !== 1'b1 || cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL run_step_noop: got fetch_en=%b ready=%b expected 1/1", fetch_en, cmd_ready); end
        do_cmd(2'd0);
        tests++; if (fetch_en !== 1'b0 || halted !== 1'b0) begin errors++; $display("[TB] FAIL host_drain: got fetch_en=%b halted=%b expected 0/0", fetch_en, halted); end
        step_clk();
        tests++; if (halted !== 1'b1 || halt_cause !== 3'd1) begin errors++; $display("[TB] FAIL host_halt: got halted=%b cause=%0d expected 1/1", halted, halt_cause); end
        do_cmd(2'd1);
        tests++; if (fetch_en !== 1'b1 || halted !== 1'b0 || halt_cause !== 3'd0) begin errors++; $display("[TB] FAIL resume2: got fetch_en=%b halted=%b cause=%0d expected 1/0/0", fetch_en, halted, halt_cause); end
    endtask

    task automatic test_breakpoint();
        pipe_empty = 1'b1;
        cmd_bp_idx = 1'b1; cmd_bp_addr = 32'h8000_0008; cmd_bp_en = 1'b1;
        do_cmd(2'd3);
        do_commit(32'h8000_0010, 1'b0, 1'b0);
        tests++; if (fetch_en !== 1'b1 || halt_cause !== 3'd0) begin errors++; $display("[TB] FAIL bp_nomatch: got fetch_en=%b cause=%0d expected 1/0", fetch_en, halt_cause); end
        do_commit(32'h8000_0008, 1'b0, 1'b0);
        tests++; if (fetch_en !== 1'b0 || halt_cause !== 3'd5) begin errors++; $display("[TB] FAIL bp_hit: got fetch_en=%b cause=%0d expected 0/5", fetch_en, halt_cause); end
        do_commit(32'h8000_0020, 1'b1, 1'b0);
        tests++; if (halted !== 1'b1 || halt_cause !== 3'd5) begin errors++; $display("[TB] FAIL bp_first_cause: got halted=%b cause=%0d expected 1/5", halted, halt_cause); end
        tests++; if (halt_pc !== 32'h8000_0020 || retire_cnt !== 32'd8) begin errors++; $display("[TB] FAIL bp_drain_commit: got pc=%h cnt=%0d expected 80000020/8", halt_pc, retire_cnt); end
        do_cmd(2'd1);
        do_commit(32'h8000_0008, 1'b0, 1'b1);
        step_clk();
        tests++; if (halted !== 1'b1 || halt_cause !== 3'd4) begin errors++; $display("[TB] FAIL bp_ivd_prio: got halted=%b cause=%0d expected 1/4", halted, halt_cause); end
        do_cmd(2'd1);
        commit_valid = 1'b1; commit_pc = 32'h8000_0008;
        do_cmd(2'd0);
        commit_valid = 1'b0;
        tests++; if (halt_cause !== 3'd5) begin errors++; $display("[TB] FAIL bp_vs_host: got %0d expected 5", halt_cause); end
        step_clk();
        tests++; if (retire_cnt !== 32'd10) begin errors++; $display("[TB] FAIL bp_cnt: got %0d expected 10", retire_cnt); end
        do_cmd(2'd1);
    endtask

    task automatic test_reset_step_wait();
        pipe_empty = 1'b1;
        do_cmd(2'd0);
        step_clk();
        do_cmd(2'd2);
        ifu_fire = 1'b1;
        step_clk();
        ifu_fire = 1'b0;
        tests++; if (fetch_en !== 1'b0 || halted !== 1'b0) begin errors++; $display("[TB] FAIL pre_reset_wait: got fetch_en=%b halted=%b expected 0/0", fetch_en, halted); end
        #2 reset = 1'b1;
        #1;
        tests++; if (fetch_en !== 1'b1 || halted !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL async_reset_flags: got fetch_en=%b halted=%b ready=%b expected 1/0/1", fetch_en, halted, cmd_ready); end
        tests++; if (retire_cnt !== 32'd0 || halt_cause !== 3'd0) begin errors++; $display("[TB] FAIL async_reset_state: got cnt=%0d cause=%0d expected 0/0", retire_cnt, halt_cause); end
        reset = 1'b0;
        do_commit(32'h8000_0008, 1'b0, 1'b0);
        tests++; if (fetch_en !== 1'b1 || halt_cause !== 3'd0 || retire_cnt !== 32'd1) begin errors++; $display("[TB] FAIL bp_cleared: got fetch_en=%b cause=%0d cnt=%0d expected 1/0/1", fetch_en, halt_cause, retire_cnt); end
    endtask

    task automatic test_counter_wrap();
        reset = 1'b1;
        #2 reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            do_commit(32'h0000_1000 + 32'(i * 4), 1'b0, 1'b0);
        end
        tests++; if (s_retire_cnt !== 4'd15) begin errors++; $display("[TB] FAIL wrap_pre: got %0d expected 15", s_retire_cnt); end
        do_commit(32'h0000_103C, 1'b0, 1'b0);
        tests++; if (s_retire_cnt !== 4'd0) begin errors++; $display("[TB] FAIL wrap_zero: got %0d expected 0", s_retire_cnt); end
        tests++; if (retire_cnt !== 32'd16) begin errors++; $display("[TB] FAIL wrap_wide: got %0d expected 16", retire_cnt); end
    endtask

    initial begin
        tests  = 0;
        errors = 0;
        test_reset();
        test_run();
        test_ebreak();
        test_step();
        test_host_halt_resume();
        test_breakpoint();
        test_reset_step_wait();
        test_counter_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/dbg_run_ctrl.md
Name: dbg_run_ctrl

Overview:
- Debug run-control sequencer between the host/debugger command interface and the core's fetch stage.
- Gates instruction fetch to implement halt, resume and single-step.
- Stops the core on a retired ebreak, invalid instruction, PC breakpoint match or host request, then drains the pipeline before reporting halted.
- Tracks the last retired PC and the retired-instruction count for the debug trace path.

Parameters:
XLEN, 32, width of PC and breakpoint addresses
NUM_BP, 2, number of PC breakpoint comparators (>=2, power of two)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
commit_valid  in  1  one instruction retires this cycle
commit_pc  in  XLEN  PC of retiring instruction
commit_brk  in  1  retiring instruction is ebreak
commit_ivd  in  1  retiring instruction is invalid
pipe_empty  in  1  no instruction in flight past fetch
ifu_fire  in  1  IFU accepted a fetch this cycle
cmd_valid  in  1  host command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  2  0=halt, 1=resume, 2=step, 3=set breakpoint
cmd_bp_idx  in  $clog2(NUM_BP)  breakpoint slot for op 3
cmd_bp_addr  in  XLEN  breakpoint PC for op 3
cmd_bp_en  in  1  breakpoint enable for op 3
fetch_en  out  1  IFU may fetch
halted  out  1  core halted and drained
halt_cause  out  3  0=none, 1=host, 2=step, 3=ebreak, 4=invalid, 5=breakpoint
halt_pc  out  XLEN  PC of last retired instruction
retire_cnt  out  CNT_W  retired-instruction count

Behaviour:
- Clock and reset: one clock; reset asynchronous, active-high. Reset forces state RUN, halt_cause=0, halt_pc=0, retire_cnt=0, all breakpoints disabled with address 0.
  - Outputs after reset: fetch_en=1, halted=0, cmd_ready=1.
  - Reset asserted mid-operation (any state) aborts immediately to these values.
- States: RUN, DRAIN, HALTED, STEP_ISSUE, STEP_WAIT. All outputs are decoded from registered state/fields.
  - fetch_en=1 in RUN and STEP_ISSUE only.
  - halted=1 in HALTED only.
  - cmd_ready=1 in RUN and HALTED only.
- Stop event on a commit: commit_valid & (commit_ivd | commit_brk | bp_hit). bp_hit = any enabled slot whose address == commit_pc.
  - Cause priority: invalid(4) > ebreak(3) > breakpoint(5).
- Every commit_valid, in any non-reset state:
  - retire_cnt += 1, wrapping at 2^CNT_W.
  - halt_pc <= commit_pc.
- RUN:
  - A stop event moves to DRAIN with its cause.
  - Otherwise an accepted halt moves to DRAIN with cause 1. When both occur in the same cycle, the commit stop event wins.
  - Accepted resume or step: no-op.
- DRAIN:
  - fetch_en=0 from the cycle after entry.
  - Commits still update halt_pc and retire_cnt. halt_cause keeps the first cause; later stop events are ignored.
  - pipe_empty=1 moves to HALTED next cycle.
- HALTED:
  - Resume moves to RUN and clears halt_cause to 0.
  - Step moves to STEP_ISSUE; halt_cause is held until the step completes.
  - Halt: no-op.
- STEP_ISSUE:
  - fetch_en=1 until ifu_fire. Moves to STEP_WAIT on the cycle ifu_fire=1.
  - If a commit occurs here, it is treated as in STEP_WAIT.
- STEP_WAIT:
  - fetch_en=0.
  - First commit_valid moves to DRAIN with cause 2, or a higher-priority stop cause if one is present.
- Set breakpoint (op 3): written on acceptance, effective from the next cycle's commits. Legal in RUN and HALTED.
- Halt latency: stop event at cycle N gives fetch_en=0 at N+1 and halted=1 one cycle after pipe_empty is first sampled high in DRAIN.
  - If pipe_empty is already 1 at N+1, halted=1 at N+2.

Test Plan:
- Run after reset: release reset, commit PCs 0x80000000, 0x80000004, 0x80000008 -> retire_cnt=3, halt_pc=0x80000008, fetch_en=1, halted=0, halt_cause=0.
- Ebreak halt: commit 0x80000010 with commit_brk, pipe_empty high 2 cycles later -> fetch_en=0 next cycle, cmd_ready=0 during DRAIN, halted=1 one cycle after pipe_empty sampled, halt_cause=3, halt_pc=0x80000010.
- Breakpoint: set slot 1 = 0x80000008 enabled, commit 0x80000008 -> halt_cause=5. Repeat with commit_ivd also set -> halt_cause=4.
- Single step from HALTED: step cmd, ifu_fire after 2 cycles, commit 0x80000014 -> fetch_en high exactly until ifu_fire, halted again with halt_cause=2, retire_cnt +1.
- Host halt/resume in RUN: halt cmd with no commit, pipe_empty=1 -> halt_cause=1. Resume -> halt_cause=0, fetch_en=1, halted=0.
- Reset in STEP_WAIT: assert reset asynchronously -> same-cycle fetch_en=1, halted=0, retire_cnt=0, breakpoints cleared (commit 0x80000008 afterwards causes no halt). Counter wrap: CNT_W=4 with 16 commits -> retire_cnt=0.
